// File: rtl/ansi_key_encoder.sv
// Key-event FIFO plus CSI sequence emitter: ASCII passes through, special keys become ESC [ sequences.
// Optional build macro CRLF_EN: key 0x0D emits 0D 0A instead of 0D alone.
`timescale 1ns/1ps
module ansi_key_encoder #(
  parameter int unsigned KEY_FIFO_DEPTH = 8
) (
  input  logic       clk100,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [7:0] key_code,
  output logic       key_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       bad_code
);

  localparam int unsigned AW = $clog2(KEY_FIFO_DEPTH);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  logic [7:0]      mem_q [KEY_FIFO_DEPTH];
  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;
  logic            key_ready_q, key_ready_d;
  logic            push, pop, fifo_empty;
  logic [7:0]      head;

  state_t          state_q, state_d;
  logic [3:0][7:0] seq_q, seq_d;
  logic [1:0]      idx_q, idx_d;
  logic [1:0]      last_q, last_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_valid_q, tx_valid_d;
  logic            bad_code_q, bad_code_d;

  logic            enc_ok;
  logic [3:0][7:0] enc_seq;
  logic [1:0]      enc_last;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign head       = mem_q[rd_ptr_q[AW-1:0]];
  assign push       = key_valid & key_ready_q;
  assign pop        = (state_q == S_IDLE) & ~fifo_empty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d    = rd_ptr_q + {{AW{1'b0}}, pop};
    // key_ready is a flop, so it is computed from the post-edge pointers
    key_ready_d = !((wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                    (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]));
  end

  always_ff @(posedge clk100) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= key_code;
  end

  always_comb begin
    enc_ok     = 1'b1;
    enc_seq    = '0;
    enc_last   = '0;
    enc_seq[0] = head;
    if (!head[7]) begin
`ifdef CRLF_EN
      if (head == 8'h0D) begin
        enc_seq[1] = 8'h0A;
        enc_last   = 2'd1;
      end
`endif
    end else begin
      enc_seq[0] = 8'h1B;
      enc_seq[1] = 8'h5B;
      enc_last   = 2'd2;
      case (head)
        8'h80: enc_seq[2] = 8'h41;
        8'h81: enc_seq[2] = 8'h42;
        8'h82: enc_seq[2] = 8'h43;
        8'h83: enc_seq[2] = 8'h44;
        8'h84: enc_seq[2] = 8'h48;
        8'h85: enc_seq[2] = 8'h46;
        8'h86: begin enc_seq[2] = 8'h33; enc_seq[3] = 8'h7E; enc_last = 2'd3; end
        8'h87: begin enc_seq[2] = 8'h35; enc_seq[3] = 8'h7E; enc_last = 2'd3; end
        8'h88: begin enc_seq[2] = 8'h36; enc_seq[3] = 8'h7E; enc_last = 2'd3; end
        8'h89: begin enc_seq[2] = 8'h32; enc_seq[3] = 8'h7E; enc_last = 2'd3; end
        default: enc_ok = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    seq_d      = seq_q;
    idx_d      = idx_q;
    last_d     = last_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    bad_code_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          if (enc_ok) begin
            seq_d      = enc_seq;
            last_d     = enc_last;
            idx_d      = '0;
            tx_data_d  = enc_seq[0];
            tx_valid_d = 1'b1;
            state_d    = S_SEND;
          end else begin
            bad_code_d = 1'b1;
          end
        end
      end
      S_SEND: begin
        if (tx_ready) begin
          if (idx_q == last_q) begin
            tx_valid_d = 1'b0;
            state_d    = S_IDLE;
          end else begin
            idx_d     = idx_q + 2'd1;
            tx_data_d = seq_q[idx_q + 2'd1];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      key_ready_q <= 1'b1;
      state_q     <= S_IDLE;
      seq_q       <= '0;
      idx_q       <= '0;
      last_q      <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      bad_code_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      key_ready_q <= key_ready_d;
      state_q     <= state_d;
      seq_q       <= seq_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      bad_code_q  <= bad_code_d;
    end
  end

  assign key_ready = key_ready_q;
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign bad_code  = bad_code_q;

endmodule
